// File: rtl/cargador_pkg.sv
// rtl/cargador_pkg.sv - shared states, constants and helpers for the instruction loader
package cargador_pkg;

  localparam int BYTES_POR_PALABRA = 4;
  localparam int ADDR_W_DEF        = 6;
  localparam int DEPTH_DEF         = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    RECIBIR  = 2'd1,
    ESCRIBIR = 2'd2,
    FIN      = 2'd3
  } estado_t;

  // A load request is only meaningful for 1..depth words
  function automatic logic cuenta_valida(input int n, input int depth);
    return (n >= 1) && (n <= depth);
  endfunction

endpackage

// File: rtl/cargador_instrucciones_if.sv
// rtl/cargador_instrucciones_if.sv - byte stream handshake between program source and loader
interface cargador_instrucciones_if;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input  byte_ready);
  modport slave  (input  byte_valid, input  byte_data, output byte_ready);

endinterface

// File: rtl/ensamblador_palabra.sv
// rtl/ensamblador_palabra.sv - packs four stream bytes big-endian into one 32-bit word
module ensamblador_palabra
  import cargador_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        limpiar,
  input  logic        acepta,
  input  logic [7:0]  byte_data,
  output logic [31:0] palabra,
  output logic        palabra_completa
);

  logic [1:0] cuenta;

  // The word is complete on the edge that takes the last byte of the group
  assign palabra_completa = acepta && (cuenta == 2'(BYTES_POR_PALABRA - 1));

  // Byte 0 lands in the MSB; the counter wraps to 0 so the next word starts clean
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cuenta  <= '0;
      palabra <= '0;
    end else if (limpiar) begin
      cuenta  <= '0;
      palabra <= '0;
    end else if (acepta) begin
      case (cuenta)
        2'd0:    palabra[31:24] <= byte_data;
        2'd1:    palabra[23:16] <= byte_data;
        2'd2:    palabra[15:8]  <= byte_data;
        default: palabra[7:0]   <= byte_data;
      endcase
      cuenta <= cuenta + 2'd1;
    end
  end

endmodule

// File: rtl/cargador_instrucciones.sv
// rtl/cargador_instrucciones.sv - streams a program image into instruction memory, holding the CPU in reset
module cargador_instrucciones
  import cargador_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W:0]           nwords,
  cargador_instrucciones_if.slave   flujo,
  output logic                      escr_instru,
  output logic [ADDR_W-1:0]         direinstru_escr,
  output logic [31:0]               instru_escr,
  output logic                      cpu_reset_n,
  output logic                      ocupado,
  output logic                      listo,
  output logic                      error
);

  estado_t           estado, estado_sig;
  logic [ADDR_W-1:0] direccion;
  logic [ADDR_W:0]   palabras;
  logic [ADDR_W:0]   nwords_q;
  logic              listo_q, error_q;
  logic              acepta, palabra_completa, ultima;
  logic              puede_iniciar, inicio_valido, inicio_invalido;

  assign acepta          = flujo.byte_valid && (estado == RECIBIR);
  assign puede_iniciar   = start && ((estado == INACTIVO) || (estado == FIN));
  assign inicio_valido   = puede_iniciar &&  cuenta_valida(int'(nwords), DEPTH);
  assign inicio_invalido = puede_iniciar && !cuenta_valida(int'(nwords), DEPTH);
  assign ultima          = ((palabras + 1'b1) == nwords_q);

  assign direinstru_escr = direccion;
  assign listo           = listo_q;
  assign error           = error_q;

  ensamblador_palabra u_ensamblador (
    .clk              (clk),
    .reset            (reset),
    .limpiar          (inicio_valido),
    .acepta           (acepta),
    .byte_data        (flujo.byte_data),
    .palabra          (instru_escr),
    .palabra_completa (palabra_completa)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= INACTIVO;
    else        estado <= estado_sig;
  end

  // Next state plus state-decoded outputs; the CPU only runs once a full image is in place
  always_comb begin
    estado_sig        = estado;
    flujo.byte_ready  = 1'b0;
    escr_instru       = 1'b0;
    ocupado           = 1'b0;
    cpu_reset_n       = 1'b0;
    case (estado)
      INACTIVO, FIN: begin
        cpu_reset_n = (estado == FIN);
        if (inicio_valido)        estado_sig = RECIBIR;
        else if (inicio_invalido) estado_sig = INACTIVO;
      end
      RECIBIR: begin
        flujo.byte_ready = 1'b1;
        ocupado          = 1'b1;
        if (palabra_completa) estado_sig = ESCRIBIR;
      end
      ESCRIBIR: begin
        escr_instru = 1'b1;
        ocupado     = 1'b1;
        estado_sig  = ultima ? FIN : RECIBIR;
      end
      default: estado_sig = INACTIVO;
    endcase
  end

  // Address/word counters and sticky status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      direccion <= '0;
      palabras  <= '0;
      nwords_q  <= '0;
      listo_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      if (inicio_valido) begin
        nwords_q  <= nwords;
        direccion <= '0;
        palabras  <= '0;
        listo_q   <= 1'b0;
        error_q   <= 1'b0;
      end else if (inicio_invalido) begin
        error_q <= 1'b1;
      end
      if (estado == ESCRIBIR) begin
        direccion <= direccion + 1'b1;
        palabras  <= palabras + 1'b1;
        if (ultima) listo_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cargador_instrucciones.sv
// tb/tb_cargador_instrucciones.sv - randomized self-checking bench for the instruction loader
module tb_cargador_instrucciones;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   nwords;
  logic              escr_instru;
  logic [ADDR_W-1:0] direinstru_escr;
  logic [31:0]       instru_escr;
  logic              cpu_reset_n, ocupado, listo, error;

  cargador_instrucciones_if flujo ();

  cargador_instrucciones #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .nwords          (nwords),
    .flujo           (flujo),
    .escr_instru     (escr_instru),
    .direinstru_escr (direinstru_escr),
    .instru_escr     (instru_escr),
    .cpu_reset_n     (cpu_reset_n),
    .ocupado         (ocupado),
    .listo           (listo),
    .error           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pruebas = 0;
  int n_fallos  = 0;

  logic [7:0]  tx[$];
  int          got_dir[$];
  logic [31:0] got_dat[$];

  task automatic comprobar(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_pruebas++;
    if (obs !== exp) begin
      n_fallos++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record every memory write; the CPU must never be released mid-load
  always @(negedge clk) begin
    if (reset) begin
      if (escr_instru) begin
        got_dir.push_back(int'(direinstru_escr));
        got_dat.push_back(instru_escr);
      end
      comprobar("cpu_libre_en_carga", {63'd0, cpu_reset_n && ocupado}, 64'd0);
    end
  end

  // Reference: word w is bytes 4w..4w+3 big-endian, written at address w mod DEPTH
  task automatic verificar_escrituras(input int n);
    logic [31:0] esperado;
    comprobar("num_escrituras", got_dat.size(), n);
    for (int w = 0; w < n && w < got_dat.size(); w++) begin
      esperado = {tx[4*w], tx[4*w+1], tx[4*w+2], tx[4*w+3]};
      comprobar("dir_escritura", got_dir[w], w % DEPTH);
      comprobar("dato_escritura", got_dat[w], esperado);
    end
  endtask

  // modo: 0 continuous, 1 alternating valid, 2 random gaps; corte >= 0 stops after that many bytes
  task automatic cargar(input int n, input int modo, input int corte);
    int   idx   = 0;
    int   ciclos = 0;
    int   total = n * 4;
    logic v, fire;
    got_dir.delete();
    got_dat.delete();
    start  = 1'b1;
    nwords = 7'(n);
    @(negedge clk);
    start = 1'b0;
    comprobar("ready_tras_start", flujo.byte_ready, 1);
    comprobar("cpu_reset_n_carga", cpu_reset_n, 0);
    comprobar("listo_borrado", listo, 0);
    comprobar("error_borrado", error, 0);
    comprobar("ocupado_carga", ocupado, 1);
    if (corte >= 0) total = corte;
    while (idx < total && ciclos < 20000) begin
      case (modo)
        0:       v = 1'b1;
        1:       v = (ciclos % 2) == 0;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      flujo.byte_valid = v;
      flujo.byte_data  = tx[idx];
      fire = v && flujo.byte_ready;
      @(negedge clk);
      ciclos++;
      if (fire) idx++;
    end
    flujo.byte_valid = 1'b0;
    comprobar("bytes_consumidos", idx, total);
    if (corte < 0) begin
      comprobar("escr_ultima", escr_instru, 1);
      comprobar("dir_ultima", direinstru_escr, (n - 1) % DEPTH);
      @(negedge clk);
      comprobar("cpu_reset_n_fin", cpu_reset_n, 1);
      comprobar("listo_fin", listo, 1);
      comprobar("ocupado_fin", ocupado, 0);
      comprobar("escr_tras_fin", escr_instru, 0);
      verificar_escrituras(n);
    end
  endtask

  task automatic inicio_invalido(input int n);
    got_dir.delete();
    got_dat.delete();
    start  = 1'b1;
    nwords = 7'(n);
    @(negedge clk);
    start = 1'b0;
    comprobar("error_invalido", error, 1);
    comprobar("ocupado_invalido", ocupado, 0);
    comprobar("ready_invalido", flujo.byte_ready, 0);
    comprobar("cpu_reset_n_invalido", cpu_reset_n, 0);
    repeat (4) @(negedge clk);
    comprobar("escrituras_invalido", got_dat.size(), 0);
    comprobar("error_mantenido", error, 1);
  endtask

  task automatic bytes_aleatorios(input int n);
    tx.delete();
    for (int i = 0; i < 4 * n; i++) tx.push_back(8'($urandom));
  endtask

  task automatic comprobar_reposo(input string tag);
    comprobar({tag, "_byte_ready"}, flujo.byte_ready, 0);
    comprobar({tag, "_escr"}, escr_instru, 0);
    comprobar({tag, "_dir"}, direinstru_escr, 0);
    comprobar({tag, "_instru"}, instru_escr, 0);
    comprobar({tag, "_cpu_reset_n"}, cpu_reset_n, 0);
    comprobar({tag, "_ocupado"}, ocupado, 0);
    comprobar({tag, "_listo"}, listo, 0);
    comprobar({tag, "_error"}, error, 0);
  endtask

  initial begin
    int n;
    reset            = 1'b0;
    start            = 1'b0;
    nwords           = '0;
    flujo.byte_valid = 1'b0;
    flujo.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    comprobar_reposo("reset");
    reset = 1'b1;
    @(negedge clk);

    tx = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04};
    cargar(2, 0, -1);

    bytes_aleatorios(1);
    cargar(1, 0, -1);

    tx = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    cargar(1, 1, -1);
    if (got_dat.size() > 0) comprobar("palabra_aabbccdd", got_dat[0], 32'hAABBCCDD);

    inicio_invalido(0);
    inicio_invalido(65);

    bytes_aleatorios(3);
    cargar(3, 2, -1);

    tx.delete();
    for (int i = 0; i < 4 * DEPTH; i++) tx.push_back(8'(i % 256));
    cargar(DEPTH, 0, -1);
    if (got_dat.size() == DEPTH) comprobar("ultima_palabra_64", got_dat[DEPTH-1], 32'hFCFDFEFF);
    comprobar("dir_envuelta", direinstru_escr, 0);

    bytes_aleatorios(1);
    cargar(1, 0, 3);
    reset = 1'b0;
    #1;
    comprobar_reposo("reset_carga");
    comprobar("escrituras_abortadas", got_dat.size(), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    comprobar("cpu_reset_n_tras_abortar", cpu_reset_n, 0);
    bytes_aleatorios(1);
    cargar(1, 0, -1);

    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 8);
      bytes_aleatorios(n);
      cargar(n, 2, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_pruebas, n_fallos);
    $finish;
  end

endmodule
